// File: rtl/gfx_sdr_arbiter_if.sv
// Requester-channel and SDRAM-port signal bundle for the graphics ROM fetch arbiter.
// The slave modport is the arbiter's view; master is the layers/SDRAM side.
interface gfx_sdr_arbiter_if #(
  parameter int NCH = 4,
  parameter int AW  = 25,
  parameter int DW  = 16
);
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_rdy;
  logic [DW-1:0]     ch_data;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_rdy;
  logic [DW-1:0]     mem_data;
  logic              busy;
  logic              err_timeout;

  modport slave (
    input  ch_req, ch_addr, mem_rdy, mem_data,
    output ch_rdy, ch_data, mem_req, mem_addr, busy, err_timeout
  );

  modport master (
    output ch_req, ch_addr, mem_rdy, mem_data,
    input  ch_rdy, ch_data, mem_req, mem_addr, busy, err_timeout
  );
endinterface

// File: rtl/gfx_sdr_arbiter.sv
// Round-robin arbiter funnelling per-layer graphics ROM fetches onto one SDRAM read port.
// Each channel holds one pending request; a newer request overwrites an unserved address.
//
// state  | meaning
// S_IDLE | no transaction in flight; arbitrate over pend | ch_req
// S_WAIT | mem_req issued, waiting for mem_rdy or timeout
module gfx_sdr_arbiter #(
  parameter int NCH     = 4,
  parameter int AW      = 25,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              RESETn,
  gfx_sdr_arbiter_if.slave bus
);
  localparam int PW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [NCH-1:0]  r_pend;
  logic [AW-1:0]   r_paddr [NCH];
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gnt;
  logic [CW-1:0]   r_cnt;
  logic            r_mem_req;
  logic [AW-1:0]   r_mem_addr;
  logic [NCH-1:0]  r_ch_rdy;
  logic [DW-1:0]   r_ch_data;
  logic            r_err;

  logic [AW-1:0]   w_addr_in [NCH];
  logic [PW-1:0]   w_rr_idx  [NCH];
  logic [NCH-1:0]  w_req;
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [AW-1:0]   w_win_addr;
  logic [PW-1:0]   w_ptr_nxt;
  logic            w_timeout;
  logic            w_grant;
  logic            w_done;
  logic            w_abort;
  logic            w_busy;
  logic [NCH-1:0]  w_rdy_vec;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_addr_in[i] = bus.ch_addr[i*AW +: AW];
      w_rr_idx[i]  = PW'((int'(r_ptr) + i) % NCH);
    end
  end

  // Same-cycle bypass: a fresh request competes without first landing in pend.
  assign w_req = r_pend | bus.ch_req;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && w_req[w_rr_idx[k]]) begin
        w_found = 1'b1;
        w_win   = w_rr_idx[k];
      end
    end
  end

  assign w_win_addr = bus.ch_req[w_win] ? w_addr_in[w_win] : r_paddr[w_win];
  assign w_ptr_nxt  = (w_win == PW'(NCH - 1)) ? '0 : w_win + 1'b1;
  // mem_rdy on the last allowed cycle wins over the abort.
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CW'(TO_LAST)) && !bus.mem_rdy;

  always_ff @(posedge clk) begin
    if (!RESETn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_rdy || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state == S_WAIT);
    w_grant   = (r_state == S_IDLE) && w_found;
    w_done    = (r_state == S_WAIT) && bus.mem_rdy;
    w_abort   = (r_state == S_WAIT) && w_timeout;
    w_rdy_vec = w_done ? (NCH'(1) << r_gnt) : '0;
  end

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      r_pend     <= '0;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_ch_rdy   <= '0;
      r_ch_data  <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < NCH; i++) r_paddr[i] <= '0;
    end else begin
      r_mem_req <= 1'b0;
      r_ch_rdy  <= w_rdy_vec;
      for (int i = 0; i < NCH; i++) begin
        if (bus.ch_req[i]) begin
          r_pend[i]  <= 1'b1;
          r_paddr[i] <= w_addr_in[i];
        end
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      // Placed after the request loop so the grant consumes a same-cycle request.
      if (w_grant) begin
        r_pend[w_win] <= 1'b0;
        r_mem_req     <= 1'b1;
        r_mem_addr    <= w_win_addr;
        r_gnt         <= w_win;
        r_ptr         <= w_ptr_nxt;
        r_cnt         <= '0;
      end
      if (w_done)  r_ch_data <= bus.mem_data;
      if (w_abort) r_err     <= 1'b1;
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.ch_rdy      = r_ch_rdy;
  assign bus.ch_data     = r_ch_data;
  assign bus.busy        = w_busy;
  assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_gfx_sdr_arbiter.sv
// Scoreboard bench for gfx_sdr_arbiter: stimulus pushes expected mem_addr / ch_rdy
// events, a negedge monitor pops and compares whenever the DUT presents them.
module tb_gfx_sdr_arbiter;
  localparam int NCH     = 4;
  localparam int AW      = 25;
  localparam int DW      = 16;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic RESETn;
  always #5 clk = ~clk;

  gfx_sdr_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus();

  gfx_sdr_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .RESETn (RESETn),
    .bus    (bus)
  );

  typedef struct {
    logic [NCH-1:0] rdy;
    logic [DW-1:0]  data;
  } rsp_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_mem [$];
  rsp_t          exp_rsp [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [AW-1:0] a;
    rsp_t          r;
    if (bus.mem_req === 1'b1) begin
      if (exp_mem.size() == 0) chk("unexpected_mem_req", bus.mem_req, 0);
      else begin
        a = exp_mem.pop_front();
        chk("mem_addr", bus.mem_addr, a);
      end
    end
    if (bus.ch_rdy !== '0 && !$isunknown(bus.ch_rdy)) begin
      if (exp_rsp.size() == 0) chk("unexpected_ch_rdy", bus.ch_rdy, 0);
      else begin
        r = exp_rsp.pop_front();
        chk("ch_rdy", bus.ch_rdy, r.rdy);
        chk("ch_data", bus.ch_data, r.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int ch, input logic [AW-1:0] a);
    bus.ch_req[ch] = 1'b1;
    bus.ch_addr[ch*AW +: AW] = a;
  endtask

  task automatic rdy_pulse(input logic [DW-1:0] d);
    bus.mem_rdy  = 1'b1;
    bus.mem_data = d;
    tick();
    bus.mem_rdy  = 1'b0;
  endtask

  // Waits for mem_req, then returns data lat cycles after the mem_req cycle.
  task automatic respond(input int lat, input int ch, input logic [DW-1:0] d);
    int   n;
    rsp_t r;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("mem_req_wait", bus.mem_req, 1);
    else begin
      repeat (lat) tick();
      r.rdy  = NCH'(1) << ch;
      r.data = d;
      exp_rsp.push_back(r);
      rdy_pulse(d);
    end
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
  endtask

  initial begin
    RESETn       = 1'b0;
    bus.ch_req   = '0;
    bus.ch_addr  = '0;
    bus.mem_rdy  = 1'b0;
    bus.mem_data = '0;
    repeat (3) tick();
    RESETn = 1'b1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_ch_rdy", bus.ch_rdy, 0);
    chk("rst_ch_data", bus.ch_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_timeout, 0);

    // Single request on ch1
    req(1, 25'h0123456); exp_mem.push_back(25'h0123456);
    tick(); bus.ch_req = '0;
    chk("t1_mem_req_latency", bus.mem_req, 1);
    chk("t1_busy_wait", bus.busy, 1);
    respond(3, 1, 16'hBEEF);
    chk("t1_busy_after", bus.busy, 0);
    tick(); tick();
    chk("t1_data_hold", bus.ch_data, 16'hBEEF);

    // Contention: two full bursts after reset, served 0..3 each time
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NCH; i++) begin
        req(i, AW'(32'h1000 * (b + 1) + i));
        exp_mem.push_back(AW'(32'h1000 * (b + 1) + i));
      end
      tick(); bus.ch_req = '0;
      for (int i = 0; i < NCH; i++) respond(2, i, DW'(16'hC000 + 16 * b + i));
    end

    // Round-robin order: after ch1 grant, ptr=2, so ch3 beats ch0
    req(1, 25'h30); exp_mem.push_back(25'h30);
    tick(); bus.ch_req = '0;
    respond(1, 1, 16'h3131);
    req(0, 25'h40); req(3, 25'h43);
    exp_mem.push_back(25'h43); exp_mem.push_back(25'h40);
    tick(); bus.ch_req = '0;
    respond(1, 3, 16'h4343);
    respond(1, 0, 16'h4040);

    // Supersede: ch2 requested twice during ch0's WAIT, only 0x200 issued
    req(0, 25'h010); exp_mem.push_back(25'h010);
    tick(); bus.ch_req = '0;
    req(2, 25'h100);
    tick(); req(2, 25'h200);
    tick(); bus.ch_req = '0;
    exp_mem.push_back(25'h200);
    begin
      rsp_t r;
      r.rdy = 4'b0001; r.data = 16'h0A0A;
      exp_rsp.push_back(r);
    end
    rdy_pulse(16'h0A0A);
    respond(2, 2, 16'h2020);

    // Re-request on the granted channel while in flight
    req(1, 25'h050); exp_mem.push_back(25'h050);
    tick(); bus.ch_req = '0;
    req(1, 25'h300); exp_mem.push_back(25'h300);
    tick(); bus.ch_req = '0;
    begin
      rsp_t r;
      r.rdy = 4'b0010; r.data = 16'h1111;
      exp_rsp.push_back(r);
    end
    rdy_pulse(16'h1111);
    respond(1, 1, 16'h2222);

    // mem_rdy on the TIMEOUT-th WAIT cycle is a success
    req(2, 25'h321); exp_mem.push_back(25'h321);
    tick(); bus.ch_req = '0;
    respond(TIMEOUT - 1, 2, 16'h6161);
    chk("edge_err_clear", bus.err_timeout, 0);
    chk("edge_busy", bus.busy, 0);

    // Timeout abort with ch0 pending behind it
    req(3, 25'h777); exp_mem.push_back(25'h777);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k == 1) begin
        bus.ch_req = '0;
        req(0, 25'h0AA); exp_mem.push_back(25'h0AA);
      end
      if (k == 2) bus.ch_req = '0;
    end
    chk("to_busy_last_cycle", bus.busy, 1);
    chk("to_err_before", bus.err_timeout, 0);
    tick();
    chk("to_busy_after", bus.busy, 0);
    chk("to_err_after", bus.err_timeout, 1);
    chk("to_no_rdy", bus.ch_rdy, 0);
    respond(2, 0, 16'h5A5A);
    chk("to_err_sticky", bus.err_timeout, 1);

    // Reset mid-WAIT, then late and stray mem_rdy
    req(1, 25'h999); exp_mem.push_back(25'h999);
    tick(); bus.ch_req = '0;
    tick();
    do_reset();
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_mem_addr", bus.mem_addr, 0);
    chk("mid_rst_ch_data", bus.ch_data, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_err", bus.err_timeout, 0);
    rdy_pulse(16'hAAAA);
    chk("late_rdy_ch_rdy", bus.ch_rdy, 0);
    chk("late_rdy_ch_data", bus.ch_data, 0);
    tick();
    rdy_pulse(16'h5555);
    chk("stray_rdy_ch_data", bus.ch_data, 0);

    // mem_rdy on the grant edge is ignored
    req(0, 25'h0BB); exp_mem.push_back(25'h0BB);
    bus.mem_rdy = 1'b1; bus.mem_data = 16'hDEAD;
    tick();
    bus.ch_req = '0; bus.mem_rdy = 1'b0;
    chk("grant_edge_busy", bus.busy, 1);
    respond(2, 0, 16'h1234);
    chk("grant_edge_data", bus.ch_data, 16'h1234);

    repeat (4) tick();
    chk("exp_mem_drained", exp_mem.size(), 0);
    chk("exp_rsp_drained", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gfx_sdr_arbiter.md
# gfx_sdr_arbiter

Round-robin arbiter that multiplexes the graphics-ROM fetch requests of the video layers (BACK1, BACK2, OBJ, FG) onto the single SDRAM ROM read port. It sits directly downstream of each layer's `sdr_addr`/`sdr_req` outputs and upstream of their `sdr_rdy`/`sdr_data` inputs, in the `clk_ram` domain. Each layer sees a private one-request/one-response channel. A newer request on a channel supersedes an unserved older one.

## Interface
Parameters:
- NCH, 4, number of requester channels (channel 0 = BACK1)
- AW, 25, SDRAM byte address width
- DW, 16, data width
- TIMEOUT, 64, max cycles waiting for `mem_rdy` before abort; 0 disables the timeout

Ports:
- clk  in  1  clock (`clk_ram` domain)
- RESETn  in  1  reset, synchronous, active-low
- ch_req  in  NCH  one-cycle request pulse per channel
- ch_addr  in  NCH*AW  packed addresses; channel i at [i*AW +: AW]; sampled only with `ch_req[i]`
- ch_rdy  out  NCH  one-cycle data-valid pulse per channel
- ch_data  out  DW  shared return data; valid only while some `ch_rdy` bit is high
- mem_req  out  1  one-cycle request pulse to the SDRAM controller
- mem_addr  out  AW  address; held stable from `mem_req` until the next grant
- mem_rdy  in  1  one-cycle pulse; `mem_data` valid
- mem_data  in  DW  SDRAM read data
- busy  out  1  high while in WAIT
- err_timeout  out  1  sticky; set on any timeout abort; cleared only by reset

## Operation
- Per-channel state: `pend[i]` bit and `paddr[i]` register.
- `ch_req[i]` sets `pend[i]` and loads `paddr[i]`. Repeated requests overwrite the address (latest wins); they never queue twice.
- Round-robin pointer `ptr` (0..NCH-1). The search starts at `ptr` and wraps.
- On grant of channel g: `ptr <= (g+1) mod NCH`.
- States: IDLE, WAIT.
- IDLE:
  - Arbitrate over `pend | ch_req` (same-cycle bypass).
  - If channel g wins: register `mem_addr <= (ch_req[g] ? ch_addr[g] : paddr[g])`, `mem_req <= 1`, `gnt <= g`, clear `pend[g]`, then go to WAIT.
  - If no channel is pending, stay in IDLE.
- WAIT:
  - `mem_req` is low (single pulse only).
  - Timeout counter increments each cycle from 0.
  - On `mem_rdy`: `ch_data <= mem_data`, `ch_rdy[gnt] <= 1`, go to IDLE.
  - If the counter reaches TIMEOUT without `mem_rdy` (TIMEOUT != 0): `err_timeout <= 1`, go to IDLE, no `ch_rdy`.
  - `ch_req` on the granted channel during WAIT sets `pend[gnt]` again; that request is served in a later grant. The in-flight response is still delivered.
- `mem_rdy` in IDLE is ignored. This includes the cycle of the grant edge.
- `ch_rdy` is one-hot or zero and high for exactly one cycle. `ch_data` holds its value until the next `mem_rdy` capture.
- Reset (synchronous, any state):
  - State IDLE, `pend=0`, `paddr=0`, `ptr=0`, counter 0.
  - Outputs: `mem_req=0`, `mem_addr=0`, `ch_rdy=0`, `ch_data=0`, `busy=0`, `err_timeout=0`.
  - An in-flight transaction is dropped. A later `mem_rdy` for it is ignored because the block is in IDLE.

## Timing
- `ch_req[i]` high in cycle c, block in IDLE with no higher-priority pending channel → `mem_req` and `mem_addr` valid in cycle c+1.
- `mem_rdy` in cycle d → `ch_rdy`/`ch_data` in cycle d+1. The state is IDLE in d+1, so the next `mem_req` can appear in d+2.
- Throughput is one transaction per (SDRAM latency + 2) cycles.
- Worst-case wait for a channel is NCH-1 transactions after its request.
- Timeout: abort on the edge ending the TIMEOUT-th WAIT cycle.
- `mem_rdy` coinciding with that edge counts as success, not timeout.
- Counter width: clog2(TIMEOUT+1), minimum 1.

## Test plan
- Single request: `ch_req=0010`, addr 0x0123456. Expect `mem_req` 1 cycle later with `mem_addr=0x0123456`. Drive `mem_rdy` 3 cycles later with data 0xBEEF. Expect `ch_rdy=0010` and `ch_data=0xBEEF` the next cycle, then `busy=0`.
- Contention: after reset, `ch_req=1111` in one cycle. Expect grants in order 0,1,2,3, exactly 4 `mem_req` pulses and 4 one-hot `ch_rdy`. A second `1111` burst is again served 0,1,2,3 (`ptr` wrapped to 0).
- Supersede: during WAIT for ch0, pulse ch2 with 0x100, then ch2 with 0x200. Expect exactly one ch2 transaction, with `mem_addr=0x200`.
- Re-request in flight: during WAIT for ch1, pulse ch1 with 0x300. Expect the current response delivered on `ch_rdy[1]`, then a second `mem_req` with 0x300.
- Timeout: TIMEOUT=16, `mem_rdy` never driven. After 16 WAIT cycles expect `err_timeout=1`, `busy=0`, no `ch_rdy`. The next pending channel is then granted, and `err_timeout` stays 1.
- Reset mid-WAIT: `RESETn=0` for 1 cycle, then a `mem_rdy` pulse with 0xAAAA. Expect all outputs 0, no `ch_rdy`, and `ch_data=0`. A stray `mem_rdy` in IDLE likewise produces no output.
